// File: rtl/stripe_mode_sequencer.sv
// Serialises striping-mode changes against AXI traffic: new addresses are held off and
// in-flight transactions drained before the remapper is handed the new mode.
module stripe_mode_sequencer #(
    parameter logic [1:0]  INIT_MODE = 2'd0,
    parameter logic [31:0] SR_ADDR   = 32'h30,
    parameter int          CNT_W     = 8,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sr_req_valid,
    input  logic                sr_req_is_write,
    input  logic [31:0]         sr_req_addr,
    input  logic [63:0]         sr_req_data,
    output logic                sr_resp_valid,
    output logic [63:0]         sr_resp_data,
    input  logic [ADDR_W-1:0]   phys_m_araddr,
    input  logic [7:0]          phys_m_arlen,
    input  logic                phys_m_arvalid,
    output logic                phys_m_arready,
    input  logic [ADDR_W-1:0]   phys_m_awaddr,
    input  logic [7:0]          phys_m_awlen,
    input  logic                phys_m_awvalid,
    output logic                phys_m_awready,
    input  logic [DATA_W-1:0]   phys_m_wdata,
    input  logic [DATA_W/8-1:0] phys_m_wstrb,
    input  logic                phys_m_wlast,
    input  logic                phys_m_wvalid,
    output logic                phys_m_wready,
    output logic [DATA_W-1:0]   phys_m_rdata,
    output logic [1:0]          phys_m_rresp,
    output logic                phys_m_rlast,
    output logic                phys_m_rvalid,
    input  logic                phys_m_rready,
    output logic [1:0]          phys_m_bresp,
    output logic                phys_m_bvalid,
    input  logic                phys_m_bready,
    output logic [ADDR_W-1:0]   phys_s_araddr,
    output logic [7:0]          phys_s_arlen,
    output logic                phys_s_arvalid,
    input  logic                phys_s_arready,
    output logic [ADDR_W-1:0]   phys_s_awaddr,
    output logic [7:0]          phys_s_awlen,
    output logic                phys_s_awvalid,
    input  logic                phys_s_awready,
    output logic [DATA_W-1:0]   phys_s_wdata,
    output logic [DATA_W/8-1:0] phys_s_wstrb,
    output logic                phys_s_wlast,
    output logic                phys_s_wvalid,
    input  logic                phys_s_wready,
    input  logic [DATA_W-1:0]   phys_s_rdata,
    input  logic [1:0]          phys_s_rresp,
    input  logic                phys_s_rlast,
    input  logic                phys_s_rvalid,
    output logic                phys_s_rready,
    input  logic [1:0]          phys_s_bresp,
    input  logic                phys_s_bvalid,
    output logic                phys_s_bready,
    output logic [1:0]          mode,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               STAT_W  = 2 * CNT_W + 6;

    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt;
    logic              held_ar, held_aw;
    logic [1:0]        pend_mode, pend_mode_nxt, mode_nxt;
    logic              pend_valid, pend_valid_nxt;
    logic              ar_open, aw_open;
    logic              ar_hs, aw_hs, r_done, b_done;
    logic              mode_wr, stat_rd;
    logic [1:0]        wr_val;
    logic [STAT_W-1:0] status;
    logic              unused_sr_data;

    // Steps an outstanding counter; a stray decrement at zero (e.g. a response
    // arriving after reset) is ignored rather than wrapping.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + 1'b1;
        if (dec && !inc && cnt != '0)
            return cnt - 1'b1;
        return cnt;
    endfunction

    assign unused_sr_data = ^sr_req_data[63:2];
    assign wr_val  = sr_req_data[1:0];
    assign mode_wr = sr_req_valid && sr_req_is_write && (sr_req_addr == SR_ADDR);
    assign stat_rd = sr_req_valid && !sr_req_is_write && (sr_req_addr == SR_ADDR);
    assign busy    = (state != IDLE);
    assign status  = {rd_cnt, wr_cnt, pend_valid, busy, pend_mode, mode};

    // A held address keeps its channel open so a started handshake is never withdrawn.
    assign ar_open = rst && (held_ar || (state == IDLE && rd_cnt != CNT_MAX));
    assign aw_open = rst && (held_aw || (state == IDLE && wr_cnt != CNT_MAX));

    assign phys_s_araddr  = phys_m_araddr;
    assign phys_s_arlen   = phys_m_arlen;
    assign phys_s_arvalid = phys_m_arvalid && ar_open;
    assign phys_m_arready = phys_s_arready && ar_open;
    assign phys_s_awaddr  = phys_m_awaddr;
    assign phys_s_awlen   = phys_m_awlen;
    assign phys_s_awvalid = phys_m_awvalid && aw_open;
    assign phys_m_awready = phys_s_awready && aw_open;
    assign phys_s_wdata   = phys_m_wdata;
    assign phys_s_wstrb   = phys_m_wstrb;
    assign phys_s_wlast   = phys_m_wlast;
    assign phys_s_wvalid  = phys_m_wvalid;
    assign phys_m_wready  = phys_s_wready;
    assign phys_m_rdata   = phys_s_rdata;
    assign phys_m_rresp   = phys_s_rresp;
    assign phys_m_rlast   = phys_s_rlast;
    assign phys_m_rvalid  = phys_s_rvalid;
    assign phys_s_rready  = phys_m_rready;
    assign phys_m_bresp   = phys_s_bresp;
    assign phys_m_bvalid  = phys_s_bvalid;
    assign phys_s_bready  = phys_m_bready;

    assign ar_hs  = phys_s_arvalid && phys_s_arready;
    assign aw_hs  = phys_s_awvalid && phys_s_awready;
    assign r_done = phys_s_rvalid && phys_m_rready && phys_s_rlast;
    assign b_done = phys_s_bvalid && phys_m_bready;

    always_comb begin
        state_nxt      = state;
        pend_mode_nxt  = pend_mode;
        pend_valid_nxt = pend_valid;
        mode_nxt       = mode;
        case (state)
            IDLE: begin
                if (mode_wr && wr_val != mode) begin
                    pend_mode_nxt = wr_val;
                    state_nxt     = DRAIN;
                end
            end
            DRAIN: begin
                if (mode_wr) begin
                    pend_mode_nxt  = wr_val;
                    pend_valid_nxt = 1'b1;
                end
                if (!held_ar && !held_aw && rd_cnt == '0 && wr_cnt == '0)
                    state_nxt = SWITCH;
            end
            SWITCH: begin
                mode_nxt = pend_mode;
                if (mode_wr) begin
                    pend_mode_nxt  = wr_val;
                    pend_valid_nxt = 1'b1;
                end
                // A write landing in this very cycle must also trigger another drain.
                state_nxt = (pend_valid || mode_wr) ? DRAIN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == DRAIN && state != DRAIN)
            pend_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            mode          <= INIT_MODE;
            pend_mode     <= INIT_MODE;
            pend_valid    <= 1'b0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            held_ar       <= 1'b0;
            held_aw       <= 1'b0;
            sr_resp_valid <= 1'b0;
            sr_resp_data  <= '0;
        end else begin
            state         <= state_nxt;
            mode          <= mode_nxt;
            pend_mode     <= pend_mode_nxt;
            pend_valid    <= pend_valid_nxt;
            rd_cnt        <= cnt_step(rd_cnt, ar_hs, r_done);
            wr_cnt        <= cnt_step(wr_cnt, aw_hs, b_done);
            held_ar       <= phys_s_arvalid && !phys_s_arready;
            held_aw       <= phys_s_awvalid && !phys_s_awready;
            sr_resp_valid <= stat_rd;
            if (stat_rd)
                sr_resp_data <= {{(64 - STAT_W){1'b0}}, status};
        end
    end

endmodule

// File: tb/tb_stripe_mode_sequencer.sv
// Directed bench for stripe_mode_sequencer: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for the counter-saturation scenario.
module tb_stripe_mode_sequencer;

    localparam logic [31:0] SR = 32'h30;

    logic        clk, rst;
    logic        sr_req_valid, sr_req_is_write;
    logic [31:0] sr_req_addr;
    logic [63:0] sr_req_data;
    logic [31:0] m_araddr, m_awaddr;
    logic [7:0]  m_arlen, m_awlen, m_wstrb;
    logic        m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;
    logic [63:0] m_wdata;
    logic        s_arready, s_awready, s_wready, s_rlast, s_rvalid, s_bvalid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;

    // main instance outputs
    logic        sr_resp_valid, m_arready, m_awready, m_wready, m_rlast, m_rvalid, m_bvalid;
    logic [63:0] sr_resp_data, m_rdata, s_wdata;
    logic [1:0]  m_rresp, m_bresp, mode;
    logic [31:0] s_araddr, s_awaddr;
    logic [7:0]  s_arlen, s_awlen, s_wstrb;
    logic        s_arvalid, s_awvalid, s_wlast, s_wvalid, s_rready, s_bready, busy;

    // saturation instance outputs
    logic        t2_sr_resp_valid, t2_m_arready, t2_m_awready, t2_m_wready, t2_m_rlast;
    logic        t2_m_rvalid, t2_m_bvalid;
    logic [63:0] t2_sr_resp_data, t2_m_rdata, t2_s_wdata;
    logic [1:0]  t2_m_rresp, t2_m_bresp, t2_mode;
    logic [31:0] t2_s_araddr, t2_s_awaddr;
    logic [7:0]  t2_s_arlen, t2_s_awlen, t2_s_wstrb;
    logic        t2_s_arvalid, t2_s_awvalid, t2_s_wlast, t2_s_wvalid, t2_s_rready;
    logic        t2_s_bready, t2_busy;

    int n_cmp = 0;
    int n_bad = 0;

    stripe_mode_sequencer dut (
        .clk(clk), .rst(rst),
        .sr_req_valid(sr_req_valid), .sr_req_is_write(sr_req_is_write),
        .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
        .sr_resp_valid(sr_resp_valid), .sr_resp_data(sr_resp_data),
        .phys_m_araddr(m_araddr), .phys_m_arlen(m_arlen), .phys_m_arvalid(m_arvalid),
        .phys_m_arready(m_arready),
        .phys_m_awaddr(m_awaddr), .phys_m_awlen(m_awlen), .phys_m_awvalid(m_awvalid),
        .phys_m_awready(m_awready),
        .phys_m_wdata(m_wdata), .phys_m_wstrb(m_wstrb), .phys_m_wlast(m_wlast),
        .phys_m_wvalid(m_wvalid), .phys_m_wready(m_wready),
        .phys_m_rdata(m_rdata), .phys_m_rresp(m_rresp), .phys_m_rlast(m_rlast),
        .phys_m_rvalid(m_rvalid), .phys_m_rready(m_rready),
        .phys_m_bresp(m_bresp), .phys_m_bvalid(m_bvalid), .phys_m_bready(m_bready),
        .phys_s_araddr(s_araddr), .phys_s_arlen(s_arlen), .phys_s_arvalid(s_arvalid),
        .phys_s_arready(s_arready),
        .phys_s_awaddr(s_awaddr), .phys_s_awlen(s_awlen), .phys_s_awvalid(s_awvalid),
        .phys_s_awready(s_awready),
        .phys_s_wdata(s_wdata), .phys_s_wstrb(s_wstrb), .phys_s_wlast(s_wlast),
        .phys_s_wvalid(s_wvalid), .phys_s_wready(s_wready),
        .phys_s_rdata(s_rdata), .phys_s_rresp(s_rresp), .phys_s_rlast(s_rlast),
        .phys_s_rvalid(s_rvalid), .phys_s_rready(s_rready),
        .phys_s_bresp(s_bresp), .phys_s_bvalid(s_bvalid), .phys_s_bready(s_bready),
        .mode(mode), .busy(busy)
    );

    stripe_mode_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .sr_req_valid(sr_req_valid), .sr_req_is_write(sr_req_is_write),
        .sr_req_addr(sr_req_addr), .sr_req_data(sr_req_data),
        .sr_resp_valid(t2_sr_resp_valid), .sr_resp_data(t2_sr_resp_data),
        .phys_m_araddr(m_araddr), .phys_m_arlen(m_arlen), .phys_m_arvalid(m_arvalid),
        .phys_m_arready(t2_m_arready),
        .phys_m_awaddr(m_awaddr), .phys_m_awlen(m_awlen), .phys_m_awvalid(m_awvalid),
        .phys_m_awready(t2_m_awready),
        .phys_m_wdata(m_wdata), .phys_m_wstrb(m_wstrb), .phys_m_wlast(m_wlast),
        .phys_m_wvalid(m_wvalid), .phys_m_wready(t2_m_wready),
        .phys_m_rdata(t2_m_rdata), .phys_m_rresp(t2_m_rresp), .phys_m_rlast(t2_m_rlast),
        .phys_m_rvalid(t2_m_rvalid), .phys_m_rready(m_rready),
        .phys_m_bresp(t2_m_bresp), .phys_m_bvalid(t2_m_bvalid), .phys_m_bready(m_bready),
        .phys_s_araddr(t2_s_araddr), .phys_s_arlen(t2_s_arlen), .phys_s_arvalid(t2_s_arvalid),
        .phys_s_arready(s_arready),
        .phys_s_awaddr(t2_s_awaddr), .phys_s_awlen(t2_s_awlen), .phys_s_awvalid(t2_s_awvalid),
        .phys_s_awready(s_awready),
        .phys_s_wdata(t2_s_wdata), .phys_s_wstrb(t2_s_wstrb), .phys_s_wlast(t2_s_wlast),
        .phys_s_wvalid(t2_s_wvalid), .phys_s_wready(s_wready),
        .phys_s_rdata(s_rdata), .phys_s_rresp(s_rresp), .phys_s_rlast(s_rlast),
        .phys_s_rvalid(s_rvalid), .phys_s_rready(t2_s_rready),
        .phys_s_bresp(s_bresp), .phys_s_bvalid(s_bvalid), .phys_s_bready(t2_s_bready),
        .mode(t2_mode), .busy(t2_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        sr_req_valid = 0; sr_req_is_write = 0; sr_req_addr = 0; sr_req_data = 0;
        m_araddr = 0; m_arlen = 0; m_arvalid = 0;
        m_awaddr = 0; m_awlen = 0; m_awvalid = 0;
        m_wdata = 0; m_wstrb = 0; m_wlast = 0; m_wvalid = 0;
        m_rready = 1; m_bready = 1;
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rvalid = 0;
        s_bresp = 0; s_bvalid = 0;
    endtask

    task automatic reset_dut;
        idle_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
        sr_req_valid = 1; sr_req_is_write = 1; sr_req_addr = a; sr_req_data = d;
        tick();
        sr_req_valid = 0; sr_req_is_write = 0;
    endtask

    task automatic sr_read(input logic [31:0] a, output logic v, output logic [63:0] d);
        sr_req_valid = 1; sr_req_is_write = 0; sr_req_addr = a;
        tick();
        v = sr_resp_valid;
        d = sr_resp_data;
        sr_req_valid = 0;
    endtask

    task automatic test_reset;
        logic v;
        logic [63:0] d;
        idle_inputs();
        rst = 0;
        m_arvalid = 1; m_awvalid = 1; s_arready = 1; s_awready = 1;
        tick();
        tick();
        n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL rst_mode got=%0d exp=0", mode); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        n_cmp++; if (s_arvalid !== 1'b0 || m_arready !== 1'b0) begin n_bad++; $display("FAIL rst_ar_gate got=%0b%0b exp=00", s_arvalid, m_arready); end
        n_cmp++; if (s_awvalid !== 1'b0 || m_awready !== 1'b0) begin n_bad++; $display("FAIL rst_aw_gate got=%0b%0b exp=00", s_awvalid, m_awready); end
        n_cmp++; if (sr_resp_valid !== 1'b0 || sr_resp_data !== 64'h0) begin n_bad++; $display("FAIL rst_resp got=%0b/%0h exp=0/0", sr_resp_valid, sr_resp_data); end
        idle_inputs();
        rst = 1;
        tick();
        sr_read(SR, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 64'h0) begin n_bad++; $display("FAIL rst_status got=%0b/%0h exp=1/0", v, d); end
        sr_read(32'h38, v, d);
        n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL other_addr_read got=%0b exp=0", v); end
    endtask

    task automatic test_passthrough;
        reset_dut();
        m_araddr = 32'h1234_5678; m_arlen = 8'd3; m_arvalid = 1; s_arready = 1;
        m_wdata = 64'hDEAD_BEEF_0000_0001; m_wstrb = 8'hF0; m_wlast = 1; m_wvalid = 1; s_wready = 1;
        s_rdata = 64'h0123_4567_89AB_CDEF; s_rresp = 2'd2; s_rvalid = 1; m_rready = 0;
        s_bresp = 2'd1; s_bvalid = 0; m_bready = 0;
        #1;
        n_cmp++; if (s_araddr !== 32'h1234_5678 || s_arlen !== 8'd3 || s_arvalid !== 1'b1 || m_arready !== 1'b1) begin n_bad++; $display("FAIL pt_ar got=%0h/%0d/%0b/%0b exp=12345678/3/1/1", s_araddr, s_arlen, s_arvalid, m_arready); end
        n_cmp++; if (s_wdata !== 64'hDEAD_BEEF_0000_0001 || s_wstrb !== 8'hF0 || s_wlast !== 1'b1 || m_wready !== 1'b1) begin n_bad++; $display("FAIL pt_w got=%0h/%0h/%0b/%0b", s_wdata, s_wstrb, s_wlast, m_wready); end
        n_cmp++; if (m_rdata !== 64'h0123_4567_89AB_CDEF || m_rresp !== 2'd2 || m_rvalid !== 1'b1 || s_rready !== 1'b0) begin n_bad++; $display("FAIL pt_r got=%0h/%0d/%0b/%0b", m_rdata, m_rresp, m_rvalid, s_rready); end
        n_cmp++; if (m_bresp !== 2'd1 || m_bvalid !== 1'b0 || s_bready !== 1'b0) begin n_bad++; $display("FAIL pt_b got=%0d/%0b/%0b exp=1/0/0", m_bresp, m_bvalid, s_bready); end
        idle_inputs();
    endtask

    task automatic test_idle_switch;
        reset_dut();
        sr_write(SR, 64'd1);
        n_cmp++; if (busy !== 1'b1 || mode !== 2'd0) begin n_bad++; $display("FAIL idle_t1 got=busy%0b/mode%0d exp=1/0", busy, mode); end
        tick();
        n_cmp++; if (busy !== 1'b1 || mode !== 2'd0) begin n_bad++; $display("FAIL idle_t2 got=busy%0b/mode%0d exp=1/0", busy, mode); end
        tick();
        n_cmp++; if (busy !== 1'b0 || mode !== 2'd1) begin n_bad++; $display("FAIL idle_t3 got=busy%0b/mode%0d exp=0/1", busy, mode); end
        sr_write(SR, 64'd1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL same_mode_noop got=%0b exp=0", busy); end
        sr_write(32'h38, 64'd2);
        n_cmp++; if (busy !== 1'b0 || mode !== 2'd1) begin n_bad++; $display("FAIL other_addr_write got=busy%0b/mode%0d exp=0/1", busy, mode); end
    endtask

    task automatic test_drain_reads;
        logic v;
        logic [63:0] d;
        reset_dut();
        s_arready = 1; m_arvalid = 1; m_arlen = 8'd3;
        for (int i = 0; i < 4; i++) begin
            m_araddr = 32'(i * 64);
            tick();
        end
        m_arvalid = 0;
        sr_read(SR, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 64'h1_0000) begin n_bad++; $display("FAIL drain_cnt_status got=%0b/%0h exp=1/10000", v, d); end
        sr_write(SR, 64'd2);
        m_arvalid = 1; m_wvalid = 1; s_wready = 1;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0 || m_arready !== 1'b0) begin n_bad++; $display("FAIL drain_ar_gated got=%0b%0b exp=00", s_arvalid, m_arready); end
        n_cmp++; if (s_wvalid !== 1'b1 || m_wready !== 1'b1) begin n_bad++; $display("FAIL drain_w_open got=%0b%0b exp=11", s_wvalid, m_wready); end
        tick(); tick(); tick();
        m_wvalid = 0;
        n_cmp++; if (mode !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL drain_hold got=mode%0d/busy%0b exp=0/1", mode, busy); end
        s_rvalid = 1; m_rready = 1;
        for (int i = 0; i < 16; i++) begin
            s_rlast = ((i % 4) == 3);
            tick();
        end
        s_rvalid = 0; s_rlast = 0;
        n_cmp++; if (mode !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL drain_h1 got=mode%0d/busy%0b exp=0/1", mode, busy); end
        tick();
        n_cmp++; if (mode !== 2'd0 || s_arvalid !== 1'b0) begin n_bad++; $display("FAIL drain_h2 got=mode%0d/arv%0b exp=0/0", mode, s_arvalid); end
        tick();
        n_cmp++; if (mode !== 2'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL drain_h3 got=mode%0d/busy%0b exp=2/0", mode, busy); end
        n_cmp++; if (s_arvalid !== 1'b1) begin n_bad++; $display("FAIL drain_reopen got=%0b exp=1", s_arvalid); end
        idle_inputs();
    endtask

    task automatic test_held;
        logic v;
        logic [63:0] d;
        reset_dut();
        m_arvalid = 1; m_arlen = 8'd0; m_araddr = 32'h100; s_arready = 0;
        sr_write(SR, 64'd3);
        n_cmp++; if (s_arvalid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL held_fwd got=arv%0b/busy%0b exp=1/1", s_arvalid, busy); end
        tick(); tick();
        n_cmp++; if (s_arvalid !== 1'b1 || mode !== 2'd0) begin n_bad++; $display("FAIL held_stable got=arv%0b/mode%0d exp=1/0", s_arvalid, mode); end
        s_arready = 1;
        #1;
        n_cmp++; if (m_arready !== 1'b1) begin n_bad++; $display("FAIL held_accept got=%0b exp=1", m_arready); end
        tick();
        s_arready = 0;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_bad++; $display("FAIL held_cleared got=%0b exp=0", s_arvalid); end
        m_arvalid = 0;
        tick(); tick();
        sr_read(SR, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 64'h401C) begin n_bad++; $display("FAIL held_status got=%0b/%0h exp=1/401c", v, d); end
        s_rvalid = 1; s_rlast = 1;
        tick();
        s_rvalid = 0; s_rlast = 0;
        n_cmp++; if (mode !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL held_h1 got=mode%0d/busy%0b exp=0/1", mode, busy); end
        tick(); tick();
        n_cmp++; if (mode !== 2'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL held_h3 got=mode%0d/busy%0b exp=3/0", mode, busy); end
        idle_inputs();
    endtask

    task automatic test_coalesce;
        reset_dut();
        sr_write(SR, 64'd2);
        sr_write(SR, 64'd3);
        n_cmp++; if (mode !== 2'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL coal_a_t2 got=mode%0d/busy%0b exp=0/1", mode, busy); end
        tick();
        n_cmp++; if (mode !== 2'd3 || busy !== 1'b1) begin n_bad++; $display("FAIL coal_a_t3 got=mode%0d/busy%0b exp=3/1", mode, busy); end
        tick(); tick();
        n_cmp++; if (mode !== 2'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL coal_a_t5 got=mode%0d/busy%0b exp=3/0", mode, busy); end
        tick(); tick();
        n_cmp++; if (mode !== 2'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL coal_a_settled got=mode%0d/busy%0b exp=3/0", mode, busy); end
        reset_dut();
        sr_write(SR, 64'd2);
        tick();
        sr_write(SR, 64'd3);
        n_cmp++; if (mode !== 2'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL coal_b_t3 got=mode%0d/busy%0b exp=2/1", mode, busy); end
        tick();
        n_cmp++; if (mode !== 2'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL coal_b_t4 got=mode%0d/busy%0b exp=2/1", mode, busy); end
        tick();
        n_cmp++; if (mode !== 2'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL coal_b_t5 got=mode%0d/busy%0b exp=3/0", mode, busy); end
        tick(); tick();
        n_cmp++; if (mode !== 2'd3 || busy !== 1'b0) begin n_bad++; $display("FAIL coal_b_settled got=mode%0d/busy%0b exp=3/0", mode, busy); end
    endtask

    task automatic test_saturation;
        reset_dut();
        s_awready = 1; m_awvalid = 1; m_awlen = 8'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (t2_m_awready !== 1'b1) begin n_bad++; $display("FAIL sat_accept_%0d got=%0b exp=1", i, t2_m_awready); end
            tick();
        end
        #1;
        n_cmp++; if (t2_m_awready !== 1'b0 || t2_s_awvalid !== 1'b0) begin n_bad++; $display("FAIL sat_block got=%0b%0b exp=00", t2_m_awready, t2_s_awvalid); end
        n_cmp++; if (m_awready !== 1'b1) begin n_bad++; $display("FAIL wide_cnt_4th got=%0b exp=1", m_awready); end
        tick();
        s_bvalid = 1;
        #1;
        n_cmp++; if (t2_m_awready !== 1'b0) begin n_bad++; $display("FAIL sat_b_cycle got=%0b exp=0", t2_m_awready); end
        tick();
        s_bvalid = 0;
        #1;
        n_cmp++; if (t2_m_awready !== 1'b1) begin n_bad++; $display("FAIL sat_after_b got=%0b exp=1", t2_m_awready); end
        tick();
        m_awvalid = 0;
        #1;
        n_cmp++; if (t2_m_awready !== 1'b0) begin n_bad++; $display("FAIL sat_full_again got=%0b exp=0", t2_m_awready); end
        sr_req_valid = 1; sr_req_is_write = 0; sr_req_addr = SR;
        tick();
        sr_req_valid = 0;
        n_cmp++; if (t2_sr_resp_valid !== 1'b1 || t2_sr_resp_data !== 64'hC0) begin n_bad++; $display("FAIL sat_status got=%0b/%0h exp=1/c0", t2_sr_resp_valid, t2_sr_resp_data); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain;
        logic v;
        logic [63:0] d;
        reset_dut();
        s_arready = 1; m_arvalid = 1;
        tick(); tick();
        m_arvalid = 0;
        sr_write(SR, 64'd1);
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmd_in_drain got=%0b exp=1", busy); end
        rst = 0;
        tick();
        rst = 1;
        n_cmp++; if (busy !== 1'b0 || mode !== 2'd0) begin n_bad++; $display("FAIL rmd_reset got=busy%0b/mode%0d exp=0/0", busy, mode); end
        s_rvalid = 1; s_rlast = 1;
        tick();
        s_rvalid = 0; s_rlast = 0;
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b0 || mode !== 2'd0) begin n_bad++; $display("FAIL rmd_dropped got=busy%0b/mode%0d exp=0/0", busy, mode); end
        sr_read(SR, v, d);
        n_cmp++; if (v !== 1'b1 || d !== 64'h0) begin n_bad++; $display("FAIL rmd_status got=%0b/%0h exp=1/0", v, d); end
    endtask

    task automatic test_back_to_back;
        reset_dut();
        sr_req_valid = 1; sr_req_is_write = 0; sr_req_addr = SR;
        tick();
        sr_req_is_write = 1; sr_req_data = 64'd1;
        #1;
        n_cmp++; if (sr_resp_valid !== 1'b1 || sr_resp_data !== 64'h0) begin n_bad++; $display("FAIL b2b_read got=%0b/%0h exp=1/0", sr_resp_valid, sr_resp_data); end
        tick();
        sr_req_is_write = 0;
        #1;
        n_cmp++; if (sr_resp_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_write got=resp%0b/busy%0b exp=0/1", sr_resp_valid, busy); end
        tick();
        sr_req_valid = 0;
        n_cmp++; if (sr_resp_valid !== 1'b1 || sr_resp_data !== 64'h14) begin n_bad++; $display("FAIL b2b_drain_status got=%0b/%0h exp=1/14", sr_resp_valid, sr_resp_data); end
        tick();
        n_cmp++; if (mode !== 2'd1 || busy !== 1'b0 || sr_resp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_done got=mode%0d/busy%0b/resp%0b exp=1/0/0", mode, busy, sr_resp_valid); end
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_passthrough();
        test_idle_switch();
        test_drain_reads();
        test_held();
        test_coalesce();
        test_saturation();
        test_reset_mid_drain();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
